// File: rtl/popcount29_weight_enum.sv
// popcount29_weight_enum
// Streams every N-bit vector with exactly k ones, in ascending numeric order,
// for a requested weight k. One vector per cycle using a single-cycle Gosper
// successor; a valid/ready handshake on the output and a request handshake
// on the input. Weights above N are rejected with a one-cycle err pulse.

module popcount29_weight_enum #(
  parameter int N  = 29,
  parameter int W  = 5,
  parameter int IW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_weight,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_vec,
  output logic          out_last,
  output logic [IW-1:0] out_index,
  output logic          err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int           CW  = $clog2(N);
  localparam logic [W-1:0] N_W = W'(N);

  state_t        state;
  logic [N-1:0]  vec_q;
  logic [N-1:0]  top_q;
  logic [IW-1:0] index_q;
  logic          last_q;
  logic          err_q;

  logic [N:0]    req_ones;
  logic [N-1:0]  req_top;
  logic          req_ok;
  logic          req_first_last;

  logic [CW-1:0] ctz;
  logic [N:0]    v_ext;
  logic [N:0]    t;
  logic [N:0]    t_inc;
  logic [N:0]    low_run;
  logic [N:0]    succ;
  logic          succ_last;

  // Decode an incoming request: first vector, final vector and legality of k
  always_comb begin
    req_ones       = ((N+1)'(1) << req_weight) - (N+1)'(1);
    req_top        = req_ones[N-1:0] << (N_W - req_weight);
    req_first_last = (req_ones == {1'b0, req_top});
    req_ok         = (req_weight <= N_W);
  end

  // Priority encoder: position of the lowest set bit of the current vector
  always_comb begin
    ctz = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_q[i]) begin
        ctz = CW'(i);
      end
    end
  end

  // Gosper successor evaluated one bit wider than the vector
  always_comb begin
    v_ext     = {1'b0, vec_q};
    t         = v_ext | (v_ext - (N+1)'(1));
    t_inc     = t + (N+1)'(1);
    low_run   = ((~t & t_inc) - (N+1)'(1)) >> ({1'b0, ctz} + (CW+1)'(1));
    succ      = t_inc | low_run;
    succ_last = (succ == {1'b0, top_q});
  end

  // Control FSM and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vec_q   <= '0;
      top_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_ok) begin
              vec_q   <= req_ones[N-1:0];
              top_q   <= req_top;
              index_q <= '0;
              last_q  <= req_first_last;
              state   <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            last_q <= 1'b0;
            state  <= IDLE;
          end else if (out_ready) begin
            if (last_q) begin
              last_q <= 1'b0;
              state  <= IDLE;
            end else begin
              vec_q   <= succ[N-1:0];
              index_q <= index_q + IW'(1);
              last_q  <= succ_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == RUN);
  assign out_vec   = vec_q;
  assign out_last  = last_q;
  assign out_index = index_q;
  assign err       = err_q;

endmodule

// File: tb/tb_popcount29_weight_enum.sv
// tb_popcount29_weight_enum
// Directed sequence of weight-class requests; every streamed vector is compared
// against a combination-position model (colex order of set-bit positions).

module tb_popcount29_weight_enum;

  localparam int N  = 29;
  localparam int W  = 5;
  localparam int IW = 27;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_weight;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic          out_last;
  logic [IW-1:0] out_index;
  logic          err;

  int compared;
  int mismatched;
  int pos[32];

  popcount29_weight_enum #(.N(N), .W(W), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_weight (req_weight),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_last   (out_last),
    .out_index  (out_index),
    .err        (err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  function automatic logic [N-1:0] model_vec(input int k);
    logic [N-1:0] v;
    v = '0;
    for (int j = 0; j < k; j++) v[pos[j]] = 1'b1;
    return v;
  endfunction

  // Next combination in ascending numeric order: bump the lowest movable one,
  // pack every one below it down to the bottom.
  task automatic model_advance(input int k);
    int lim;
    for (int i = 0; i < k; i++) begin
      lim = (i == k - 1) ? N : pos[i+1];
      if (pos[i] + 1 < lim) begin
        pos[i] = pos[i] + 1;
        for (int j = 0; j < i; j++) pos[j] = j;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input int k);
    @(negedge clk);
    check_output("req_ready_before_req", req_ready, 1);
    req_valid  = 1'b1;
    req_weight = W'(k);
    @(negedge clk);
    req_valid  = 1'b0;
    req_weight = W'($urandom);
  endtask

  task automatic run_class(input int k, input bit rand_ready, input int abort_at);
    longint total;
    longint idx;
    int     cycles;
    int     budget;
    bit     done;
    bit     aborted;
    bit     rdy;
    apply_stimulus(k);
    for (int j = 0; j < 32; j++) pos[j] = j;
    total   = binom(N, k);
    idx     = 0;
    cycles  = 0;
    budget  = (abort_at >= 0) ? abort_at * 4 + 100 : int'(total) * 4 + 100;
    done    = 1'b0;
    aborted = 1'b0;
    while (!done) begin
      check_output("out_valid", out_valid, 1);
      check_output("out_vec", out_vec, model_vec(k));
      check_output("out_index", out_index, idx);
      check_output("out_last", out_last, (idx == total - 1));
      check_output("popcount", $countones(out_vec), k);
      if (abort_at == idx) begin
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check_output("abort_valid", out_valid, 0);
        check_output("abort_req_ready", req_ready, 1);
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        rdy       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        @(negedge clk);
        cycles++;
        if (rdy) begin
          if (idx == total - 1) done = 1'b1;
          else begin
            idx++;
            model_advance(k);
          end
        end
        if (!done && cycles > budget) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL cycle_budget: k=%0d stopped at index %0d of %0d", k, idx, total);
          done = 1'b1;
        end
      end
    end
    out_ready = 1'b0;
    if (!aborted) begin
      check_output("end_valid", out_valid, 0);
      check_output("end_req_ready", req_ready, 1);
    end
  endtask

  // Directed test sequence
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_weight = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_req_ready", req_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_out_vec", out_vec, 0);
    check_output("reset_out_last", out_last, 0);
    check_output("reset_out_index", out_index, 0);
    check_output("reset_err", err, 0);
    rst = 1'b0;

    $display("[TB] k=0, k=1, k=2 with continuous out_ready");
    run_class(0, 1'b0, -1);
    run_class(1, 1'b0, -1);
    run_class(2, 1'b0, -1);

    $display("[TB] k=29 single vector, k=30 rejected");
    run_class(29, 1'b0, -1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_weight = W'(30);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("err_pulse", err, 1);
    check_output("err_no_valid", out_valid, 0);
    check_output("err_req_ready", req_ready, 1);
    @(negedge clk);
    check_output("err_cleared", err, 0);
    check_output("err_still_no_valid", out_valid, 0);

    $display("[TB] k=3 with random backpressure");
    run_class(3, 1'b1, -1);

    $display("[TB] k=14 abort and restart");
    run_class(14, 1'b1, 100);
    run_class(14, 1'b0, 3);

    $display("[TB] reset in the middle of a class");
    apply_stimulus(14);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_output("midrun_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_output("midrun_rst_req_ready", req_ready, 1);
    check_output("midrun_rst_out_valid", out_valid, 0);
    check_output("midrun_rst_out_vec", out_vec, 0);
    check_output("midrun_rst_out_last", out_last, 0);
    check_output("midrun_rst_out_index", out_index, 0);
    check_output("midrun_rst_err", err, 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    run_class(1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
